// File: rtl/usib_csr_slave.sv
// UltraSimpleInterfaceBus slave endpoint: decodes interconnect commands for one block,
// holds RW controls, exposes RO status and keeps a sticky W1C event register with IRQ.
//
// state | meaning
// sIdle | no command held; next hit executes
// sHold | a command executed and is still on the bus; only a new address word executes
module usib_csr_slave #(
  parameter logic [3:0]  pBlockId      = 4'd0,
  parameter int          pUsiBusWidth  = 32,
  parameter int          pCsrAdrsWidth = 16,
  parameter int          pRwNum        = 4,
  parameter int          pRoNum        = 2,
  parameter logic [31:0] pRwInit       = 32'h0
) (
  input  logic                    iSCLK,
  input  logic                    iSRST,
  input  logic [pUsiBusWidth-1:0] iSUsiAdrs,
  input  logic [pUsiBusWidth-1:0] iSUsiWd,
  output logic [pUsiBusWidth-1:0] oSUsiRd,
  output logic [pRwNum*32-1:0]    oCsrRw,
  output logic [pRwNum-1:0]       oCsrWe,
  input  logic [pRoNum*32-1:0]    iCsrRo,
  input  logic [31:0]             iEvent,
  output logic                    oIrq
);

  localparam int cEvtSts = pRwNum + pRoNum;
  localparam int cEvtEn  = cEvtSts + 1;

  typedef enum logic {sIdle, sHold} tState;

  tState                     state, stateNext;
  logic [pUsiBusWidth-1:0]   rLastAdrs;
  logic [31:0]               rwReg [pRwNum];
  logic [31:0]               rEvtSts, rEvtEn;

  logic [1:0]                cmd;
  logic [3:0]                blkId;
  logic [pCsrAdrsWidth-1:0]  csrIdx;
  logic                      hit, exec, doWr, doRd;

  logic [31:0]               rdMux;
  logic [pRwNum-1:0]         rwWrEn;
  logic [31:0]               stsClr;
  logic                      enWr;

  assign cmd    = iSUsiAdrs[31:30];
  assign blkId  = iSUsiAdrs[19:16];
  assign csrIdx = iSUsiAdrs[pCsrAdrsWidth-1:0];
  assign hit    = (cmd != 2'b00) && (blkId == pBlockId);
  // The full address word, including ignored bits, distinguishes a new transaction.
  assign exec   = hit && ((state == sIdle) || (iSUsiAdrs != rLastAdrs));
  assign doWr   = exec && cmd[0];
  assign doRd   = exec && cmd[1];

  always_ff @(posedge iSCLK) begin
    if (iSRST) state <= sIdle;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    if (!hit)      stateNext = sIdle;
    else if (exec) stateNext = sHold;
  end

  always_comb begin
    rdMux  = '0;
    rwWrEn = '0;
    stsClr = '0;
    enWr   = 1'b0;
    for (int k = 0; k < pRwNum; k++) begin
      if (csrIdx == pCsrAdrsWidth'(k)) begin
        rdMux     = rwReg[k];
        rwWrEn[k] = doWr;
      end
    end
    for (int k = 0; k < pRoNum; k++) begin
      if (csrIdx == pCsrAdrsWidth'(pRwNum + k)) rdMux = iCsrRo[k*32 +: 32];
    end
    if (csrIdx == pCsrAdrsWidth'(cEvtSts)) begin
      rdMux = rEvtSts;
      if (doWr) stsClr = iSUsiWd;
    end
    if (csrIdx == pCsrAdrsWidth'(cEvtEn)) begin
      rdMux = rEvtEn;
      enWr  = doWr;
    end
  end

  always_ff @(posedge iSCLK) begin
    if (iSRST) begin
      for (int k = 0; k < pRwNum; k++) rwReg[k] <= pRwInit;
      rEvtSts   <= '0;
      rEvtEn    <= '0;
      oSUsiRd   <= '0;
      oCsrWe    <= '0;
      oIrq      <= 1'b0;
      rLastAdrs <= '0;
    end else begin
      for (int k = 0; k < pRwNum; k++) begin
        if (rwWrEn[k]) rwReg[k] <= iSUsiWd;
      end
      oCsrWe  <= rwWrEn;
      // Set wins over clear so an event arriving during the W1C is not lost.
      rEvtSts <= (rEvtSts & ~stsClr) | iEvent;
      if (enWr) rEvtEn <= iSUsiWd;
      oIrq    <= |(rEvtSts & rEvtEn);
      if (doRd) oSUsiRd <= rdMux;
      if (exec) rLastAdrs <= iSUsiAdrs;
    end
  end

  for (genvar g = 0; g < pRwNum; g++) begin : gRwOut
    assign oCsrRw[g*32 +: 32] = rwReg[g];
  end

endmodule

// File: doc/usib_csr_slave.md
Name: usib_csr_slave

Overview:
- Slave-side endpoint of the UltraSimpleInterfaceBus; one instance per functional block.
- Decodes the bus address and write data broadcast by the bus interconnect, and executes write, read and write+read commands once per transaction.
- Holds the block's RW control registers, exposes RO status inputs and keeps a sticky event/IRQ register.
- Returns read data on its 32-bit slice of the interconnect's slave read-data bus.

Parameters:
- pBlockId, 0, 4-bit block ID this endpoint answers to (address bits [19:16]).
- pUsiBusWidth, 32, bus width; only 32 is supported.
- pCsrAdrsWidth, 16, CSR index field width (address bits [15:0]).
- pRwNum, 4, number of 32-bit RW control registers.
- pRoNum, 2, number of 32-bit RO status registers.
- pRwInit, 32'h0, reset value of every RW register.

Ports:
- iSCLK  in  1  bus clock
- iSRST  in  1  synchronous active-high reset
- iSUsiAdrs  in  32  interconnect address/command word: [31:30] cmd (00 none, 01 W, 10 R, 11 WR), [19:16] block ID, [15:0] CSR index
- iSUsiWd  in  32  interconnect write data
- oSUsiRd  out  32  read data to interconnect slice
- oCsrRw  out  pRwNum*32  RW register contents; register k occupies [k*32+31:k*32]
- oCsrWe  out  pRwNum  one-cycle pulse on the cycle after RW register k is written
- iCsrRo  in  pRoNum*32  RO status values, sampled at read execution
- iEvent  in  32  event pulses, one bit per event source
- oIrq  out  1  registered OR of (EVT_STS & EVT_EN)

Behaviour:
- Hit: cmd != 00 and iSUsiAdrs[19:16] == pBlockId. Address bits [29:20] are ignored.
- CSR map by index:
  - 0..pRwNum-1: RW registers.
  - pRwNum..pRwNum+pRoNum-1: RO registers (iCsrRo).
  - E = pRwNum+pRoNum: EVT_STS, write-1-to-clear (W1C).
  - E+1: EVT_EN, RW.
  - Other indices: reads return 0; writes are ignored.
- FSM states: IDLE and HOLD.
  - Execute condition: hit && (state == IDLE || iSUsiAdrs != rLastAdrs).
  - On execute: rLastAdrs <= iSUsiAdrs; state <= HOLD.
  - In HOLD with cmd == 00 or no hit: state <= IDLE.
  - In HOLD with the same address word: no action, so a held command executes exactly once.
  - A change in iSUsiWd alone does not start a new transaction.
- Write (cmd 01 or 11) executed at edge T:
  - Target register updated; new value visible from T+1.
  - oCsrWe[k] is high for exactly cycle T+1 and only for RW index k.
  - EVT_STS write clears the bits that are 1 in iSUsiWd.
- Read (cmd 10 or 11) executed at edge T:
  - oSUsiRd is loaded at T+1 and holds until the next executed read.
  - For WR, read data is the pre-write value.
- Non-hit cycles never change oSUsiRd.
- EVT_STS update each cycle: STS <= (STS & ~clr) | iEvent. On simultaneous set and clear of a bit, set wins.
- oIrq is registered: it reflects STS/EN one cycle after they change.
- Reset (synchronous, iSRST=1):
  - RW registers = pRwInit.
  - EVT_STS = 0, EVT_EN = 0.
  - oSUsiRd = 0, oCsrWe = 0, oIrq = 0.
  - state = IDLE, rLastAdrs = 0.
  - Commands and events presented during reset are ignored.
  - A hit still present on the first cycle after reset deassertion executes, because state is IDLE.
- Latency: command to register/readback is 1 cycle. Through the interconnect, the master sees read data 2 cycles after issuing the command.

Test Plan:
- Reset, pBlockId=2: adrs=32'h4002_0001, wd=32'hDEAD_BEEF held 5 cycles -> oCsrRw[63:32]=DEADBEEF from T+1; oCsrWe=4'b0010 for exactly one cycle.
- adrs=32'h8002_0004 with iCsrRo[31:0]=32'h1234_5678 -> oSUsiRd=12345678 at T+1. Then adrs=32'h8003_0004 (other ID) -> oSUsiRd unchanged.
- RW[0]=32'h0000_00AA; adrs=32'hC002_0000, wd=32'h55 -> oSUsiRd=0xAA and RW[0]=0x55 at T+1.
- EVT_EN=1; iEvent=1 pulse -> oIrq=1 two cycles later. W1C write of 1 to index 6 in the same cycle as a new iEvent[0] pulse -> STS[0] stays 1. W1C alone -> oIrq=0.
- Back-to-back writes to indices 0 then 1, each held 1 cycle with no idle between -> both execute, oCsrWe=0001 then 0010. Same address held 3 cycles with changing wd -> only the first wd is written.
- iSRST asserted while adrs=32'h4002_0000 is held -> no write during reset; on the first cycle after release the write executes once. Index 9 read -> 0; index 9 write -> no register change.
